// File: rtl/bcd_calc_sequencer.sv
// Sequences LOAD/ADD/SUB/CLEAR commands onto an external two-digit BCD adder/subtractor and keeps the accumulator.
// Optional operand digit checking is enabled by defining BCD_SEQ_DIGIT_CHECK_EN.
module bcd_calc_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_d10,
    input  logic [3:0] cmd_d1,
    output logic [3:0] dp_in1_10,
    output logic [3:0] dp_in1_1,
    output logic [3:0] dp_in2_10,
    output logic [3:0] dp_in2_1,
    output logic       dp_operator,
    input  logic [3:0] dp_res10,
    input  logic [3:0] dp_res1,
    input  logic       dp_flag,
    output logic [3:0] acc_10,
    output logic [3:0] acc_1,
    output logic       res_valid,
    output logic       err
);

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       digits_bad;
    logic       exec;

`ifdef BCD_SEQ_DIGIT_CHECK_EN
    assign digits_bad = (cmd_d10 > 4'd9) || (cmd_d1 > 4'd9);
`else
    assign digits_bad = 1'b0;
`endif

    always_comb begin
        cmd_ready = (state == IDLE);
        accept    = cmd_valid && (state == IDLE);
        // Arithmetic only launches when clean: a sticky error or bad digit consumes the command in IDLE.
        exec      = accept && (cmd_op != OP_LOAD) && (cmd_op != OP_CLEAR) && !err && !digits_bad;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (exec) state_nxt = DRIVE;
            DRIVE:   if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_10      <= 4'd0;
            acc_1       <= 4'd0;
            dp_in1_10   <= 4'd0;
            dp_in1_1    <= 4'd0;
            dp_in2_10   <= 4'd0;
            dp_in2_1    <= 4'd0;
            dp_operator <= 1'b0;
            cnt         <= 4'd0;
            res_valid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (accept) begin
                case (cmd_op)
                    OP_LOAD: begin
                        if (digits_bad) begin
                            err <= 1'b1;
                        end else begin
                            acc_10    <= cmd_d10;
                            acc_1     <= cmd_d1;
                            err       <= 1'b0;
                            res_valid <= 1'b1;
                        end
                    end
                    OP_CLEAR: begin
                        acc_10    <= 4'd0;
                        acc_1     <= 4'd0;
                        err       <= 1'b0;
                        res_valid <= 1'b1;
                    end
                    default: begin
                        if (digits_bad) begin
                            err <= 1'b1;
                        end else if (exec) begin
                            dp_in1_10   <= acc_10;
                            dp_in1_1    <= acc_1;
                            dp_in2_10   <= cmd_d10;
                            dp_in2_1    <= cmd_d1;
                            dp_operator <= cmd_op[1];
                            cnt         <= CNT_INIT;
                        end
                    end
                endcase
            end else if (state == DRIVE) begin
                // Datapath result is only trusted on the final settle edge.
                if (cnt == 4'd0) begin
                    if (dp_flag) begin
                        err <= 1'b1;
                    end else begin
                        acc_10    <= dp_res10;
                        acc_1     <= dp_res1;
                        res_valid <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_calc_sequencer.sv
// Bench for bcd_calc_sequencer: arithmetic datapath model that is only correct once inputs have settled,
// plus a decimal reference model of the accumulator and error flag.
module tb_bcd_calc_sequencer;

    localparam int SETTLE = 2;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_d10 = 4'd0;
    logic [3:0] cmd_d1 = 4'd0;
    logic [3:0] dp_in1_10, dp_in1_1, dp_in2_10, dp_in2_1;
    logic       dp_operator;
    logic [3:0] dp_res10, dp_res1;
    logic       dp_flag;
    logic [3:0] acc_10, acc_1;
    logic       res_valid;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_a10 = 4'd0;
    logic [3:0] m_a1  = 4'd0;
    logic       m_err = 1'b0;

    bcd_calc_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_d10(cmd_d10), .cmd_d1(cmd_d1),
        .dp_in1_10(dp_in1_10), .dp_in1_1(dp_in1_1),
        .dp_in2_10(dp_in2_10), .dp_in2_1(dp_in2_1),
        .dp_operator(dp_operator),
        .dp_res10(dp_res10), .dp_res1(dp_res1), .dp_flag(dp_flag),
        .acc_10(acc_10), .acc_1(acc_1),
        .res_valid(res_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Datapath model: answer is garbage until its inputs have been stable long enough.
    logic [16:0] dp_snap = '0;
    int          stable_cnt = 0;

    always @(posedge clk) begin
        #1;
        if ({dp_in1_10, dp_in1_1, dp_in2_10, dp_in2_1, dp_operator} !== dp_snap) begin
            dp_snap    = {dp_in1_10, dp_in1_1, dp_in2_10, dp_in2_1, dp_operator};
            stable_cnt = 0;
        end else if (stable_cnt < 1000) begin
            stable_cnt = stable_cnt + 1;
        end
    end

    always @* begin
        int v1, v2, r;
        v1 = int'(dp_in1_10) * 10 + int'(dp_in1_1);
        v2 = int'(dp_in2_10) * 10 + int'(dp_in2_1);
        r  = dp_operator ? v1 - v2 : v1 + v2;
        dp_flag = 1'b0;
        if (r > 99) begin r = r - 100; dp_flag = 1'b1; end
        if (r < 0)  begin r = r + 100; dp_flag = 1'b1; end
        dp_res10 = 4'(r / 10);
        dp_res1  = 4'(r % 10);
        if (stable_cnt < SETTLE - 1) begin
            dp_flag  = 1'b1;
            dp_res10 = 4'hF;
            dp_res1  = 4'hF;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] dp_now();
        return {dp_in1_10, dp_in1_1, dp_in2_10, dp_in2_1, dp_operator};
    endfunction

    // Called #1 after the accept edge of an executed ADD/SUB; returns #1 after the capture edge.
    task automatic wait_capture(input logic sub, input logic [3:0] o10, input logic [3:0] o1);
        int v1, v2, r, edges;
        logic fl;
        logic [16:0] snap;
        snap = dp_now();
        v1 = int'(m_a10) * 10 + int'(m_a1);
        v2 = int'(o10) * 10 + int'(o1);
        r  = sub ? v1 - v2 : v1 + v2;
        fl = (r > 99) || (r < 0);
        r  = (r + 100) % 100;
        edges = 0;
        while (cmd_ready !== 1'b1 && edges < 20) begin
            check("dp_stable_in_drive", 32'(dp_now()), 32'(snap));
            check("res_valid_low_in_drive", res_valid, 1'b0);
            @(posedge clk); #1;
            edges++;
        end
        check("capture_latency", edges, SETTLE);
        if (fl) m_err = 1'b1;
        else begin
            m_a10 = 4'(r / 10);
            m_a1  = 4'(r % 10);
        end
        check("res_valid_at_capture", res_valid, !fl);
        check("acc_after_capture", {acc_10, acc_1}, {m_a10, m_a1});
        check("err_after_capture", err, m_err);
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] d10, input logic [3:0] d1);
        logic bad, rv;
        logic [16:0] snap;
        @(negedge clk);
        check("ready_before_cmd", cmd_ready, 1'b1);
        snap = dp_now();
        cmd_op = op; cmd_d10 = d10; cmd_d1 = d1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
`ifdef BCD_SEQ_DIGIT_CHECK_EN
        bad = (d10 > 4'd9) || (d1 > 4'd9);
`else
        bad = 1'b0;
`endif
        rv = 1'b0;
        if ((op == OP_ADD || op == OP_SUB) && !bad && !m_err) begin
            check("ready_low_after_exec", cmd_ready, 1'b0);
            check("dp_in1", {dp_in1_10, dp_in1_1}, {m_a10, m_a1});
            check("dp_in2", {dp_in2_10, dp_in2_1}, {d10, d1});
            check("dp_operator", dp_operator, op[1]);
            wait_capture(op[1], d10, d1);
        end else begin
            if (op == OP_CLEAR) begin
                m_a10 = 4'd0; m_a1 = 4'd0; m_err = 1'b0; rv = 1'b1;
            end else if (bad) begin
                m_err = 1'b1;
            end else if (op == OP_LOAD) begin
                m_a10 = d10; m_a1 = d1; m_err = 1'b0; rv = 1'b1;
            end
            check("res_valid_after_cmd", res_valid, rv);
            check("ready_after_cmd", cmd_ready, 1'b1);
            check("dp_unchanged", 32'(dp_now()), 32'(snap));
            check("acc_after_cmd", {acc_10, acc_1}, {m_a10, m_a1});
            check("err_after_cmd", err, m_err);
        end
        @(posedge clk); #1;
        check("res_valid_single_pulse", res_valid, 1'b0);
    endtask

    initial begin
        logic [3:0] r10, r1;
        logic [1:0] rop;
        logic [16:0] snap;

        #3;
        check("reset_ready", cmd_ready, 1'b1);
        check("reset_acc", {acc_10, acc_1}, 8'h00);
        check("reset_dp", 32'(dp_now()), 32'd0);
        check("reset_res_valid", res_valid, 1'b0);
        check("reset_err", err, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // Basic add, overflow/underflow and sticky error behaviour.
        issue(OP_LOAD, 4'd4, 4'd5);
        issue(OP_ADD, 4'd3, 4'd7);
        check("acc_82", {acc_10, acc_1}, 8'h82);
        issue(OP_SUB, 4'd9, 4'd0);
        check("err_after_underflow", err, 1'b1);
        issue(OP_ADD, 4'd0, 4'd1);
        check("acc_held_82", {acc_10, acc_1}, 8'h82);
        issue(OP_CLEAR, 4'd7, 4'd7);
        check("acc_cleared", {acc_10, acc_1}, 8'h00);
        issue(OP_LOAD, 4'd9, 4'd9);
        issue(OP_ADD, 4'd0, 4'd1);
        check("acc_held_99", {acc_10, acc_1}, 8'h99);
        issue(OP_LOAD, 4'd1, 4'd0);
        check("err_cleared_by_load", err, 1'b0);

        // Command held valid throughout DRIVE is accepted right after return to IDLE.
        issue(OP_LOAD, 4'd2, 4'd0);
        @(negedge clk);
        cmd_op = OP_ADD; cmd_d10 = 4'd3; cmd_d1 = 4'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = OP_SUB; cmd_d10 = 4'd5; cmd_d1 = 4'd5;
        check("ready_low_held_valid", cmd_ready, 1'b0);
        wait_capture(1'b0, 4'd3, 4'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("held_sub_accepted", cmd_ready, 1'b0);
        check("held_sub_dp_in2", {dp_in2_10, dp_in2_1}, 8'h55);
        check("held_sub_operator", dp_operator, 1'b1);
        check("rv_not_twice", res_valid, 1'b0);
        wait_capture(1'b1, 4'd5, 4'd5);
        @(posedge clk); #1;
        issue(OP_CLEAR, 4'd0, 4'd0);

        // Reset in the middle of DRIVE aborts the operation.
        issue(OP_LOAD, 4'd1, 4'd2);
        @(negedge clk);
        cmd_op = OP_ADD; cmd_d10 = 4'd1; cmd_d1 = 4'd1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk); rst_n = 1'b0; #1;
        check("mid_reset_acc", {acc_10, acc_1}, 8'h00);
        check("mid_reset_ready", cmd_ready, 1'b1);
        check("mid_reset_dp", 32'(dp_now()), 32'd0);
        m_a10 = 4'd0; m_a1 = 4'd0; m_err = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no_rv_after_reset", res_valid, 1'b0);
            check("acc_zero_after_reset", {acc_10, acc_1}, 8'h00);
        end

        // Non-decimal operand digit.
        issue(OP_LOAD, 4'd3, 4'd3);
        issue(OP_LOAD, 4'd0, 4'hA);
`ifdef BCD_SEQ_DIGIT_CHECK_EN
        check("bad_digit_err", err, 1'b1);
        check("bad_digit_acc", {acc_10, acc_1}, 8'h33);
        issue(OP_ADD, 4'hC, 4'd1);
        check("bad_add_acc", {acc_10, acc_1}, 8'h33);
`else
        check("raw_digit_acc1", acc_1, 4'hA);
`endif
        issue(OP_CLEAR, 4'd0, 4'd0);

        // Random command mix with decimal operands.
        snap = '0;
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == OP_CLEAR && $urandom_range(0, 2) != 0) rop = OP_ADD;
            r10 = 4'($urandom_range(0, 9));
            r1  = 4'($urandom_range(0, 9));
`ifdef BCD_SEQ_DIGIT_CHECK_EN
            if ($urandom_range(0, 7) == 0) r1 = 4'($urandom_range(10, 15));
`endif
            issue(rop, r10, r1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
